// File: rtl/line_rasterizer.sv
// Line rasterizer: pops lines from a queue and walks each one with Bresenham,
// issuing clipped framebuffer pixel writes under valid/ready backpressure.
module line_rasterizer #(
    parameter int FB_W  = 640,
    parameter int FB_H  = 480,
    parameter int X_OFF = 320,
    parameter int Y_OFF = 240
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               q_empty,
    input  logic signed [12:0] q_start_x,
    input  logic signed [12:0] q_start_y,
    input  logic signed [12:0] q_end_x,
    input  logic signed [12:0] q_end_y,
    input  logic        [3:0]  q_intensity,
    output logic               q_read,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic        [9:0]  pix_x,
    output logic        [8:0]  pix_y,
    output logic        [3:0]  pix_i,
    output logic               busy
);
    // state | meaning
    // IDLE  | waiting for a queued line; pops and latches the head
    // SETUP | derives deltas, step directions and initial error
    // DRAW  | visits one point per step cycle until the end point
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic signed [12:0] x0_q, y0_q, x1_q, y1_q, cx_q, cy_q;
    logic signed [12:0] x0_d, y0_d, x1_d, y1_d, cx_d, cy_d;
    logic [3:0]         int_q, int_d;
    logic [13:0]        dx_q, dx_d;
    logic signed [14:0] dy_q, dy_d, err_q, err_d;
    logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

    logic signed [13:0] diff_x, diff_y;
    logic [13:0]        abs_x, abs_y;
    logic signed [14:0] px, py;
    logic signed [15:0] e2;
    logic               in_range, step, at_end, step_x, step_y;

    assign diff_x = 14'(x1_q) - 14'(x0_q);
    assign diff_y = 14'(y1_q) - 14'(y0_q);
    assign abs_x  = diff_x[13] ? 14'(-diff_x) : 14'(diff_x);
    assign abs_y  = diff_y[13] ? 14'(-diff_y) : 14'(diff_y);

    assign px = 15'(cx_q) + 15'(X_OFF);
    assign py = 15'(cy_q) + 15'(Y_OFF);
    assign in_range = !px[14] && (px < 15'(FB_W)) && !py[14] && (py < 15'(FB_H));

    assign e2     = {err_q, 1'b0};
    assign step_x = e2 >= 16'(dy_q);
    assign step_y = e2 <= $signed({2'b00, dx_q});
    assign at_end = (cx_q == x1_q) && (cy_q == y1_q);

    assign pix_valid = (state_q == DRAW) && in_range;
    assign step      = !pix_valid || pix_ready;
    assign q_read    = (state_q == IDLE) && !q_empty && !rst;
    assign busy      = state_q != IDLE;
    assign pix_x     = pix_valid ? px[9:0] : '0;
    assign pix_y     = pix_valid ? py[8:0] : '0;
    assign pix_i     = pix_valid ? int_q : '0;

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        int_d    = int_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        case (state_q)
            IDLE: begin
                if (q_read) begin
                    x0_d    = q_start_x;
                    y0_d    = q_start_y;
                    x1_d    = q_end_x;
                    y1_d    = q_end_y;
                    int_d   = q_intensity;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (int_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    dx_d     = abs_x;
                    dy_d     = -$signed({1'b0, abs_y});
                    err_d    = $signed({1'b0, abs_x}) - $signed({1'b0, abs_y});
                    sx_neg_d = diff_x[13];
                    sy_neg_d = diff_y[13];
                    cx_d     = x0_q;
                    cy_d     = y0_q;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (step) begin
                    if (at_end) begin
                        state_d = IDLE;
                    end else begin
                        // both axis decisions are taken from the pre-step error
                        err_d = err_q + (step_x ? dy_q : 15'sd0)
                                      + (step_y ? $signed({1'b0, dx_q}) : 15'sd0);
                        if (step_x) cx_d = sx_neg_q ? cx_q - 13'sd1 : cx_q + 13'sd1;
                        if (step_y) cy_d = sy_neg_q ? cy_q - 13'sd1 : cy_q + 13'sd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            int_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            int_q    <= int_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: a small line queue, a pixel/pop logger
// and hand-computed pixel sequences and cycle numbers.
module tb_line_rasterizer;
    logic               clk_in = 1'b0;
    logic               rst = 1'b1;
    logic               q_empty;
    logic signed [12:0] q_start_x, q_start_y, q_end_x, q_end_y;
    logic        [3:0]  q_intensity;
    logic               q_read;
    logic               pix_valid;
    logic               pix_ready = 1'b1;
    logic        [9:0]  pix_x;
    logic        [8:0]  pix_y;
    logic        [3:0]  pix_i;
    logic               busy;

    line_rasterizer dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .q_empty     (q_empty),
        .q_start_x   (q_start_x),
        .q_start_y   (q_start_y),
        .q_end_x     (q_end_x),
        .q_end_y     (q_end_y),
        .q_intensity (q_intensity),
        .q_read      (q_read),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_i       (pix_i),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // line queue
    logic signed [12:0] lq_x0 [0:31];
    logic signed [12:0] lq_y0 [0:31];
    logic signed [12:0] lq_x1 [0:31];
    logic signed [12:0] lq_y1 [0:31];
    logic        [3:0]  lq_i  [0:31];
    logic [4:0] head = '0;
    logic [4:0] tail = '0;

    assign q_empty     = (head == tail);
    assign q_start_x   = lq_x0[head];
    assign q_start_y   = lq_y0[head];
    assign q_end_x     = lq_x1[head];
    assign q_end_y     = lq_y1[head];
    assign q_intensity = lq_i[head];

    always @(posedge clk_in) if (q_read) head <= head + 5'd1;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // logger: accepted pixels, pop cycles, hold-under-stall checks
    int px_a [0:2047];
    int py_a [0:2047];
    int pi_a [0:2047];
    int pc_a [0:2047];
    int qc_a [0:31];
    int n  = 0;
    int nq = 0;
    logic       hold_v = 1'b0;
    logic [9:0] hx;
    logic [8:0] hy;
    logic [3:0] hi;

    always @(negedge clk_in) begin
        if (hold_v) begin
            check("hold_valid", pix_valid, 1);
            check("hold_x", pix_x, hx);
            check("hold_y", pix_y, hy);
            check("hold_i", pix_i, hi);
        end
        hold_v = pix_valid && !pix_ready && !rst;
        hx = pix_x;
        hy = pix_y;
        hi = pix_i;
        if (pix_valid && pix_ready && n < 2048) begin
            px_a[n] = pix_x;
            py_a[n] = pix_y;
            pi_a[n] = pix_i;
            pc_a[n] = cyc;
            n++;
        end
        if (q_read) begin
            check("qread_legal", {29'd0, q_empty, busy, rst}, 0);
            if (nq < 32) qc_a[nq] = cyc;
            nq++;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input int x0, input int y0, input int x1, input int y1, input int i);
        lq_x0[tail] = 13'(x0);
        lq_y0[tail] = 13'(y0);
        lq_x1[tail] = 13'(x1);
        lq_y1[tail] = 13'(y1);
        lq_i[tail]  = 4'(i);
        tail = tail + 5'd1;
    endtask

    task automatic wait_qread(input int budget, output int c);
        int k;
        k = 0;
        @(negedge clk_in);
        while (!q_read && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        check("qread_seen", q_read, 1);
        c = cyc;
    endtask

    task automatic wait_done(input int budget, output int cd);
        int k;
        k = 0;
        @(negedge clk_in);
        while ((busy || !q_empty) && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        check("done_in_budget", (busy || !q_empty) ? 0 : 1, 1);
        cd = cyc;
    endtask

    task automatic check_pix(input string tag, input int idx, input int x, input int y,
                             input int i, input int c);
        check({tag, "_x"}, px_a[idx], x);
        check({tag, "_y"}, py_a[idx], y);
        check({tag, "_i"}, pi_a[idx], i);
        check({tag, "_cyc"}, pc_a[idx], c);
    endtask

    initial begin
        int c, cd, b, qb;

        // reset with a line already queued: no pop while rst is high
        push(-2, 0, 2, 0, 9);
        tick();
        tick();
        @(negedge clk_in);
        check("rst_q_read", q_read, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_pix_i", pix_i, 0);
        b = n;
        tick();
        rst = 1'b0;

        // horizontal line
        wait_qread(20, c);
        wait_done(40, cd);
        check("h_count", n - b, 5);
        for (int k = 0; k < 5; k++) check_pix("h", b + k, 318 + k, 240, 9, c + 2 + k);
        check("h_done", cd, c + 7);

        // same line with a 3-cycle stall on the second pixel
        tick();
        b = n;
        push(-2, 0, 2, 0, 9);
        wait_qread(20, c);
        tick();
        tick();
        tick();
        pix_ready = 1'b0;
        @(negedge clk_in);
        check("bp_valid", pix_valid, 1);
        check("bp_x", pix_x, 319);
        tick();
        tick();
        @(negedge clk_in);
        check("bp_x_late", pix_x, 319);
        tick();
        pix_ready = 1'b1;
        wait_done(40, cd);
        check("bp_count", n - b, 5);
        check_pix("bp0", b, 318, 240, 9, c + 2);
        for (int k = 1; k < 5; k++) check_pix("bp", b + k, 318 + k, 240, 9, c + 5 + k);
        check("bp_done", cd, c + 10);

        // diagonal
        tick();
        b = n;
        push(0, 0, 3, -3, 5);
        wait_qread(20, c);
        wait_done(40, cd);
        check("d_count", n - b, 4);
        for (int k = 0; k < 4; k++) check_pix("d", b + k, 320 + k, 240 - k, 5, c + 2 + k);
        check("d_done", cd, c + 6);

        // steep
        tick();
        b = n;
        push(0, 0, 1, 4, 6);
        wait_qread(20, c);
        wait_done(40, cd);
        check("s_count", n - b, 5);
        check_pix("s0", b + 0, 320, 240, 6, c + 2);
        check_pix("s1", b + 1, 320, 241, 6, c + 3);
        check_pix("s2", b + 2, 321, 242, 6, c + 4);
        check_pix("s3", b + 3, 321, 243, 6, c + 5);
        check_pix("s4", b + 4, 321, 244, 6, c + 6);
        check("s_done", cd, c + 7);

        // clipped line, discarded line, then a short line, queued back-to-back
        tick();
        b = n;
        qb = nq;
        push(-330, 0, -318, 0, 3);
        push(0, 0, 5, 5, 0);
        push(1, 1, 2, 1, 7);
        wait_qread(20, c);
        wait_done(100, cd);
        check("c_pops", nq - qb, 3);
        check("c_pop2_cyc", qc_a[qb + 1], c + 15);
        check("c_pop3_cyc", qc_a[qb + 2], c + 17);
        check("c_count", n - b, 5);
        check_pix("c0", b + 0, 0, 240, 3, c + 12);
        check_pix("c1", b + 1, 1, 240, 3, c + 13);
        check_pix("c2", b + 2, 2, 240, 3, c + 14);
        check_pix("c3", b + 3, 321, 241, 7, c + 19);
        check_pix("c4", b + 4, 322, 241, 7, c + 20);
        check("c_done", cd, c + 21);

        // reset on the third pixel of a 10-pixel line, next line still queued
        tick();
        b = n;
        qb = nq;
        push(0, 0, 9, 0, 2);
        push(-1, -1, -1, -1, 15);
        wait_qread(20, c);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk_in);
        check("mr_pix_valid", pix_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_q_read", q_read, 0);
        tick();
        rst = 1'b0;
        wait_done(40, cd);
        check("mr_pops", nq - qb, 2);
        check("mr_pop2_cyc", qc_a[qb + 1], c + 6);
        check("mr_count", n - b, 4);
        for (int k = 0; k < 3; k++) check_pix("mr", b + k, 320 + k, 240, 2, c + 2 + k);
        check_pix("mr_zero", b + 3, 319, 239, 15, c + 8);
        check("mr_done", cd, c + 9);

        // full-range diagonal, mostly clipped
        tick();
        b = n;
        push(-4095, 4095, 4095, -4095, 1);
        wait_qread(20, c);
        wait_done(9000, cd);
        check("big_count", n - b, 480);
        check_pix("big_first", b, 81, 479, 1, c + 2 + 3856);
        check_pix("big_last", b + 479, 560, 0, 1, c + 2 + 4335);
        check("big_done", cd, c + 8193);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
